// File: rtl/spi_xfer_counter_if.sv
// rtl/spi_xfer_counter_if.sv - control/status bundle between SPI control register and transfer sequencer
interface spi_xfer_counter_if #(
    parameter int CNT_W = 10,
    parameter int N_CS  = 4
);
    logic                     start_i;
    logic [CNT_W-2:0]         n_tx_end_i;
    logic [$clog2(N_CS)-1:0]  cs_sel_i;
    logic                     byte_done_i;
    logic                     abort_i;
    logic                     busy_o;
    logic [CNT_W-1:0]         cnt_o;
    logic                     last_byte_o;
    logic                     fin_trans_o;
    logic                     aborted_o;
    logic [N_CS-1:0]          cs_n_o;

    modport master (
        output start_i, n_tx_end_i, cs_sel_i, byte_done_i, abort_i,
        input  busy_o, cnt_o, last_byte_o, fin_trans_o, aborted_o, cs_n_o
    );

    modport slave (
        input  start_i, n_tx_end_i, cs_sel_i, byte_done_i, abort_i,
        output busy_o, cnt_o, last_byte_o, fin_trans_o, aborted_o, cs_n_o
    );
endinterface

// File: rtl/spi_xfer_counter.sv
// rtl/spi_xfer_counter.sv - SPI multi-byte transfer sequencer with byte counter and chip-select framing
// Optional abort support is enabled by defining SPI_XFER_ABORT_EN.
module spi_xfer_counter #(
    parameter int CNT_W = 10,
    parameter int N_CS  = 4
) (
    input  logic                clk_i,
    input  logic                rst,
    spi_xfer_counter_if.slave   bus
);
    localparam int SEL_W = $clog2(N_CS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-2:0]   n_end_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               hit_end;
    logic               abort_hit;
    logic               busy_q, busy_d;
    logic               fin_q, fin_d;
    logic               aborted_q, aborted_d;
    logic [N_CS-1:0]    cs_n_q, cs_n_d;

    assign hit_end = (cnt_q == {1'b0, n_end_q});

`ifdef SPI_XFER_ABORT_EN
    assign abort_hit = (state == RUN) && bus.abort_i;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start_i) state_nxt = RUN;
            RUN: begin
                // abort takes priority over a coincident final byte
                if (abort_hit)                         state_nxt = IDLE;
                else if (bus.byte_done_i && hit_end)   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they align with it.
    always_comb begin
        sel_d     = (state == IDLE) ? bus.cs_sel_i : sel_q;
        busy_d    = (state_nxt != IDLE);
        fin_d     = (state_nxt == DONE);
        aborted_d = abort_hit;
        cs_n_d    = '1;
        if (state_nxt == RUN) cs_n_d[sel_d] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            n_end_q   <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            aborted_q <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            if (state == IDLE && bus.start_i) begin
                n_end_q <= bus.n_tx_end_i;
                sel_q   <= bus.cs_sel_i;
                cnt_q   <= '0;
            end else if (state == RUN && bus.byte_done_i && !abort_hit) begin
                cnt_q   <= cnt_q + 1'b1;
            end
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            aborted_q <= aborted_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.cnt_o       = cnt_q;
    assign bus.last_byte_o = (state == RUN) && hit_end;
    assign bus.fin_trans_o = fin_q;
    assign bus.aborted_o   = aborted_q;
    assign bus.cs_n_o      = cs_n_q;
endmodule

// File: tb/tb_spi_xfer_counter.sv
// tb/tb_spi_xfer_counter.sv - directed self-checking bench for spi_xfer_counter
module tb_spi_xfer_counter;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;
    int   fin_seen;

    always #50 clk = ~clk;

    spi_xfer_counter_if #(.CNT_W(10), .N_CS(4)) bus ();

    spi_xfer_counter #(.CNT_W(10), .N_CS(4)) dut (
        .clk_i (clk),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic byte_pulse();
        bus.byte_done_i = 1'b1;
        tick();
        bus.byte_done_i = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.start_i     = 1'b0;
        bus.n_tx_end_i  = '0;
        bus.cs_sel_i    = '0;
        bus.byte_done_i = 1'b0;
        bus.abort_i     = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_cnt", bus.cnt_o, 0);
        chk("rst_fin", bus.fin_trans_o, 0);
        chk("rst_abt", bus.aborted_o, 0);
        chk("rst_cs", bus.cs_n_o, 4'hf);
        chk("rst_last", bus.last_byte_o, 0);
        rst = 1'b1;
        tick();

        // basic 4-byte transfer to slave 2
        bus.n_tx_end_i = 9'd3;
        bus.cs_sel_i   = 2'd2;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        chk("b_busy", bus.busy_o, 1);
        chk("b_cnt0", bus.cnt_o, 0);
        chk("b_cs", bus.cs_n_o, 4'b1011);
        chk("b_last0", bus.last_byte_o, 0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 7; g++) tick();
            chk("b_last_gap", bus.last_byte_o, (i == 3) ? 1 : 0);
            chk("b_cs_gap", bus.cs_n_o, 4'b1011);
            if (i == 2) begin
                // mid-run start and parameter changes must be ignored
                bus.start_i    = 1'b1;
                bus.n_tx_end_i = 9'd0;
                bus.cs_sel_i   = 2'd0;
                tick();
                bus.start_i    = 1'b0;
                chk("ign_cnt", bus.cnt_o, 2);
                chk("ign_cs", bus.cs_n_o, 4'b1011);
                chk("ign_last", bus.last_byte_o, 0);
            end
            byte_pulse();
            chk("b_cnt", bus.cnt_o, i + 1);
            chk("b_fin", bus.fin_trans_o, (i == 3) ? 1 : 0);
        end
        chk("b_done_cs", bus.cs_n_o, 4'hf);
        chk("b_done_busy", bus.busy_o, 1);
        tick();
        chk("b_idle_fin", bus.fin_trans_o, 0);
        chk("b_idle_busy", bus.busy_o, 0);
        chk("b_idle_cnt", bus.cnt_o, 4);
        byte_pulse();
        chk("ign_idle_bd", bus.cnt_o, 4);

        // single-byte transfer to slave 1
        bus.n_tx_end_i = 9'd0;
        bus.cs_sel_i   = 2'd1;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        chk("s_last", bus.last_byte_o, 1);
        chk("s_cs", bus.cs_n_o, 4'b1101);
        tick();
        tick();
        chk("s_last2", bus.last_byte_o, 1);
        byte_pulse();
        chk("s_fin", bus.fin_trans_o, 1);
        chk("s_cnt", bus.cnt_o, 1);
        chk("s_last_done", bus.last_byte_o, 0);
        tick();
        chk("s_idle", bus.busy_o, 0);

        // maximum length: 512 bytes to slave 3
        bus.n_tx_end_i = 9'd511;
        bus.cs_sel_i   = 2'd3;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        chk("m_cs", bus.cs_n_o, 4'b0111);
        fin_seen = 0;
        for (int i = 0; i < 511; i++) begin
            byte_pulse();
            if (bus.fin_trans_o) fin_seen++;
        end
        chk("m_cnt511", bus.cnt_o, 511);
        chk("m_last", bus.last_byte_o, 1);
        byte_pulse();
        if (bus.fin_trans_o) fin_seen++;
        chk("m_cnt512", bus.cnt_o, 512);
        tick();
        if (bus.fin_trans_o) fin_seen++;
        chk("m_fin_once", fin_seen, 1);
        chk("m_idle_cnt", bus.cnt_o, 512);

        // reset in the middle of a transfer
        bus.n_tx_end_i = 9'd3;
        bus.cs_sel_i   = 2'd0;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        byte_pulse();
        byte_pulse();
        chk("r_cnt2", bus.cnt_o, 2);
        rst = 1'b0;
        tick();
        chk("r_busy", bus.busy_o, 0);
        chk("r_cnt", bus.cnt_o, 0);
        chk("r_cs", bus.cs_n_o, 4'hf);
        chk("r_last", bus.last_byte_o, 0);
        chk("r_fin", bus.fin_trans_o, 0);
        rst = 1'b1;
        bus.n_tx_end_i = 9'd1;
        bus.cs_sel_i   = 2'd1;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        chk("r_new_cs", bus.cs_n_o, 4'b1101);
        byte_pulse();
        byte_pulse();
        chk("r_new_fin", bus.fin_trans_o, 1);
        chk("r_new_cnt", bus.cnt_o, 2);
        tick();

        // abort coincident with the final byte of a 4-byte transfer
        bus.n_tx_end_i = 9'd3;
        bus.cs_sel_i   = 2'd2;
        bus.start_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        byte_pulse();
        byte_pulse();
        byte_pulse();
        bus.abort_i     = 1'b1;
        bus.byte_done_i = 1'b1;
        tick();
        bus.abort_i     = 1'b0;
        bus.byte_done_i = 1'b0;
`ifdef SPI_XFER_ABORT_EN
        chk("a_pulse", bus.aborted_o, 1);
        chk("a_fin", bus.fin_trans_o, 0);
        chk("a_cnt", bus.cnt_o, 3);
        chk("a_cs", bus.cs_n_o, 4'hf);
        chk("a_busy", bus.busy_o, 0);
        tick();
        chk("a_pulse_end", bus.aborted_o, 0);
`else
        chk("a_pulse", bus.aborted_o, 0);
        chk("a_fin", bus.fin_trans_o, 1);
        chk("a_cnt", bus.cnt_o, 4);
        tick();
        chk("a_idle", bus.busy_o, 0);
`endif

        // start and abort together in IDLE: transfer starts
        bus.n_tx_end_i = 9'd0;
        bus.cs_sel_i   = 2'd0;
        bus.start_i    = 1'b1;
        bus.abort_i    = 1'b1;
        tick();
        bus.start_i    = 1'b0;
        bus.abort_i    = 1'b0;
        chk("sa_busy", bus.busy_o, 1);
        chk("sa_cs", bus.cs_n_o, 4'b1110);
        chk("sa_abt", bus.aborted_o, 0);
        byte_pulse();
        chk("sa_fin", bus.fin_trans_o, 1);
        chk("sa_cnt", bus.cnt_o, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/spi_xfer_counter.md
# spi_xfer_counter

Parametrised SPI transaction sequencer that counts completed bytes in a multi-byte transfer and frames the transfer with chip-select and completion signals. It sits between the SPI peripheral's control register and its shift-register datapath. It latches the programmed byte count and target slave at start, and counts `byte_done_i` pulses. It asserts the selected active-low chip-select for the whole transfer and issues a one-cycle `fin_trans_o` pulse when `n_tx_end + 1` bytes have completed.

## Interface
Parameters:
- `CNT_W`, 10, counter width. `n_tx_end_i` is `CNT_W-1` bits wide, so `n_tx_end + 1` always fits in `cnt_o`. Minimum value 2.
- `N_CS`, 4, number of chip-select lines. Must be a power of two, at least 2.

Ports:
- `clk_i`, in, 1, system clock (10 MHz).
- `rst`, in, 1, reset: synchronous, active-low.
- `start_i`, in, 1, start request. Sampled only in IDLE.
- `n_tx_end_i`, in, `CNT_W-1`, byte count minus one. Latched at start.
- `cs_sel_i`, in, `$clog2(N_CS)`, slave index. Latched at start.
- `byte_done_i`, in, 1, one-cycle pulse from the shift register when a byte finishes.
- `abort_i`, in, 1, abort request. Functional only with `SPI_XFER_ABORT_EN`.
- `busy_o`, out, 1, high in RUN and DONE.
- `cnt_o`, out, `CNT_W`, bytes completed.
- `last_byte_o`, out, 1, high in RUN while `cnt_o == n_tx_end_latched`.
- `fin_trans_o`, out, 1, one-cycle end-of-transfer pulse.
- `aborted_o`, out, 1, one-cycle abort pulse. Constant 0 without the macro.
- `cs_n_o`, out, `N_CS`, active-low chip-selects.

## Operation
- FSM states:
  - IDLE: `busy_o`=0, `cs_n_o` all ones. `cnt_o` holds the final count of the previous transfer so software can read it.
  - RUN: `busy_o`=1, `cs_n_o[cs_sel_latched]`=0, all other chip-selects 1.
  - DONE: `busy_o`=1, `fin_trans_o`=1, `cs_n_o` all ones.
- IDLE → RUN on `start_i`=1:
  - latch `n_tx_end_i` and `cs_sel_i`;
  - clear `cnt_o` to 0.
- RUN, `byte_done_i`=1: `cnt_o` increments by 1.
  - If `cnt_o` was `n_tx_end_latched` before the increment, next state is DONE and `cnt_o` becomes `n_tx_end+1`.
- DONE → IDLE unconditionally after one cycle.
- `start_i` is ignored in RUN and DONE. No queuing.
- `byte_done_i` is ignored in IDLE and DONE.
- Counter arithmetic is unsigned, width `CNT_W`. Wrap-around cannot occur by construction.
- `n_tx_end_i`=0 gives a single-byte transfer. `last_byte_o` is high for the entire RUN state.
- `n_tx_end_i` changing during RUN has no effect.
- Reset values, applied at any time including mid-transfer:
  - state IDLE, `cnt_o`=0, `busy_o`=0;
  - `last_byte_o`=0, `fin_trans_o`=0, `aborted_o`=0;
  - `cs_n_o` all ones, latched registers 0.

## Timing
- All outputs are registered except `last_byte_o`, which is combinational from state, `cnt_o` and the latched count.
- Start latency: `start_i` high at edge k gives `busy_o`=1, `cnt_o`=0 and the chip-select asserted after edge k.
- Count latency: `byte_done_i` high at edge k gives the updated `cnt_o` after edge k.
- Completion: last `byte_done_i` at edge k gives `fin_trans_o`=1 and the chip-select deasserted for exactly the cycle after edge k. IDLE follows after edge k+1.
- Minimum gap from `fin_trans_o` to the next RUN is 2 cycles. `start_i` is accepted at the edge that enters IDLE+1.
- Simultaneous `start_i` and `abort_i` in IDLE: the transfer starts and the abort is ignored.

## Configuration
- Macro: `SPI_XFER_ABORT_EN`.
- Defined:
  - `abort_i`=1 in RUN moves to IDLE at the next edge, with `aborted_o`=1 for that one cycle and `cs_n_o` all ones.
  - No `fin_trans_o` is issued, and `cnt_o` holds the partial count.
  - Abort wins over a simultaneous final `byte_done_i`: `cnt_o` is not incremented.
  - `abort_i` is ignored in IDLE and DONE.
- Undefined: `abort_i` is unconnected internally and `aborted_o` is tied to 0. All other behaviour is identical.

## Test plan
- Basic transfer: `n_tx_end_i`=3, `cs_sel_i`=2, start, then 4 `byte_done_i` pulses 8 cycles apart → `cs_n_o`=4'b1011 during RUN; `cnt_o` steps 0→4; `last_byte_o` high only while `cnt_o`=3; one `fin_trans_o` pulse; `cnt_o`=4 held in IDLE.
- Single byte: `n_tx_end_i`=0 → `last_byte_o` high throughout RUN; `fin_trans_o` one cycle after the first `byte_done_i`; `cnt_o`=1.
- Max count: `CNT_W`=10, `n_tx_end_i`=511, 512 pulses → `cnt_o`=512, no wrap, `fin_trans_o` once.
- Ignored inputs: second `start_i` and a `n_tx_end_i` change mid-RUN, plus `byte_done_i` in IDLE → no effect on count or target.
- Reset mid-transfer: `rst`=0 with `cnt_o`=2 → after the next edge all outputs are at reset values; a new start works normally.
- With `SPI_XFER_ABORT_EN`: abort coincident with the final `byte_done_i` of a 4-byte transfer → `aborted_o` pulse, no `fin_trans_o`, `cnt_o`=3. Without the macro, the same stimulus completes normally with `cnt_o`=4.
